// File: rtl/robo_sensor_filter.sv
// ---------------------------------------------------------------------------
// robo_sensor_filter
//
// Conditions the four raw robot sensors (head, left, under, barrier) before
// they reach the navigation FSM. Each raw input passes through a two-flop
// synchroniser, then a per-channel debounce counter. A new level is accepted
// only after DEB_CYCLES consecutive enabled samples differ from the current
// filtered level. A registered one-cycle strobe flags any accepted change.
// All state updates on posedge, so outputs are settled before the FSM samples
// them on negedge.
//
// Parameters:
//   DEB_CYCLES  consecutive differing samples needed to accept a level (>=1)
//   CNT_W       debounce counter width, must hold DEB_CYCLES-1
//   RST_VAL     reset level of {head,left,under,barrier}
//
// Ports:
//   clock        in   system clock, posedge
//   reset        in   asynchronous, active-high
//   sample_en    in   1 = counters advance, 0 = counters and outputs frozen
//   head_raw     in   raw front-obstacle sensor (asynchronous)
//   left_raw     in   raw left-wall sensor (asynchronous)
//   under_raw    in   raw under-body sensor (asynchronous)
//   barrier_raw  in   raw debris sensor (asynchronous)
//   head         out  filtered head
//   left         out  filtered left
//   under        out  filtered under
//   barrier      out  filtered barrier
//   sensor_chg   out  one-cycle pulse after any filtered bit changed
//   glitch_cnt   out  saturating count of rejected glitches
//
// Optional feature: define SENSOR_GLITCH_CNT_EN to build the glitch counter.
// Without it glitch_cnt is tied to zero; filtering is identical either way.
// ---------------------------------------------------------------------------
module robo_sensor_filter #(
  parameter int         DEB_CYCLES = 4,
  parameter int         CNT_W      = 3,
  parameter logic [3:0] RST_VAL    = 4'b1001
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample_en,
  input  logic       head_raw,
  input  logic       left_raw,
  input  logic       under_raw,
  input  logic       barrier_raw,
  output logic       head,
  output logic       left,
  output logic       under,
  output logic       barrier,
  output logic       sensor_chg,
  output logic [7:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  // Bit order throughout: {head, left, under, barrier}
  logic [3:0]       raw_p0;
  logic [3:0]       sync_p1;
  logic [3:0]       sync_p2;
  logic [3:0]       filt;
  logic [3:0]       filt_nxt;
  logic [3:0]       upd;
  logic [CNT_W-1:0] cnt     [4];
  logic [CNT_W-1:0] cnt_nxt [4];

  assign raw_p0 = {head_raw, left_raw, under_raw, barrier_raw};

  // Per-channel debounce decision, evaluated on the fully synchronised sample
  always_comb begin
    filt_nxt = filt;
    upd      = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt[i] = cnt[i];
      if (sample_en) begin
        if (sync_p2[i] == filt[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_MAX) begin
          filt_nxt[i] = sync_p2[i];
          cnt_nxt[i]  = '0;
          upd[i]      = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Stage boundary: synchroniser, debounce state and change strobe.
  // Sync flops reset to RST_VAL so reset release cannot look like a change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p1    <= RST_VAL;
      sync_p2    <= RST_VAL;
      filt       <= RST_VAL;
      sensor_chg <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_p1    <= raw_p0;
      sync_p2    <= sync_p1;
      filt       <= filt_nxt;
      sensor_chg <= |upd;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign head    = filt[3];
  assign left    = filt[2];
  assign under   = filt[1];
  assign barrier = filt[0];

`ifdef SENSOR_GLITCH_CNT_EN
  logic glitch_any;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A glitch is a count in progress that is abandoned because the sample
  // fell back to the filtered level; simultaneous aborts count once.
  always_comb begin
    glitch_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sample_en && (sync_p2[i] == filt[i]) && (cnt[i] != '0)) begin
        glitch_any = 1'b1;
      end
    end
  end

  // Stage boundary: glitch counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      glitch_cnt <= 8'h00;
    end else if (glitch_any) begin
      glitch_cnt <= sat_inc(glitch_cnt);
    end
  end
`else
  assign glitch_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_robo_sensor_filter.sv
// ---------------------------------------------------------------------------
// tb_robo_sensor_filter
//
// Bench for robo_sensor_filter (DEB_CYCLES=4, RST_VAL=4'b1001). A behavioural
// model tracks, per channel, the recent enabled samples since the last
// accepted change; a level is accepted when the last four all differ from the
// filtered value. A compare process checks every cycle against the model;
// directed scenarios pin the model with literal expectations, followed by a
// fast-toggle phase and a randomised phase with random resets and freezes.
// ---------------------------------------------------------------------------
module tb_robo_sensor_filter;

  localparam int         DEB = 4;
  localparam logic [3:0] RST = 4'b1001;
`ifdef SENSOR_GLITCH_CNT_EN
  localparam int GL_EN = 1;
`else
  localparam int GL_EN = 0;
`endif

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic       sample_en = 1'b1;
  logic [3:0] raw       = 4'b0000;
  logic       head, left, under, barrier, sensor_chg;
  logic [7:0] glitch_cnt;
  logic [3:0] outv;

  assign outv = {head, left, under, barrier};

  always #5 clock = ~clock;

  robo_sensor_filter #(
    .DEB_CYCLES (DEB),
    .CNT_W      (3),
    .RST_VAL    (RST)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_en   (sample_en),
    .head_raw    (raw[3]),
    .left_raw    (raw[2]),
    .under_raw   (raw[1]),
    .barrier_raw (raw[0]),
    .head        (head),
    .left        (left),
    .under       (under),
    .barrier     (barrier),
    .sensor_chg  (sensor_chg),
    .glitch_cnt  (glitch_cnt)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]     m_filt;
  logic           m_chg;
  int             m_glitch;
  logic [DEB-1:0] m_hist [4];
  int             m_nv   [4];
  logic [3:0]     m_pipe [$];
  logic [3:0]     m_d;
  logic           m_gl;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_filt   = RST;
      m_chg    = 1'b0;
      m_glitch = 0;
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = '0;
        m_nv[i]   = 0;
      end
      m_pipe.delete();
      m_pipe.push_back(RST);
      m_pipe.push_back(RST);
    end else begin
      // the value acted on now is the raw level captured two edges ago
      m_pipe.push_back(raw);
      m_d = m_pipe[0];
      void'(m_pipe.pop_front());
      m_chg = 1'b0;
      if (sample_en) begin
        m_gl = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (m_d[i] == m_filt[i] && m_nv[i] > 0 && m_hist[i][0] != m_filt[i]) m_gl = 1'b1;
          m_hist[i] = {m_hist[i][DEB-2:0], m_d[i]};
          m_nv[i]   = (m_nv[i] < DEB) ? m_nv[i] + 1 : DEB;
          if (m_nv[i] == DEB && m_hist[i] == {DEB{~m_filt[i]}}) begin
            m_filt[i] = m_d[i];
            m_nv[i]   = 0;
            m_chg     = 1'b1;
          end
        end
        if (GL_EN != 0 && m_gl && m_glitch < 255) m_glitch++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clock) begin
    #1;
    if (chk_on) begin
      check("cyc_out", int'(outv), int'(m_filt));
      check("cyc_chg", int'(sensor_chg), int'(m_chg));
      check("cyc_glitch", int'(glitch_cnt), m_glitch);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    logic [3:0] hold;

    // 1. reset with raw=0000, then release with raw=1001
    reset = 1'b1; raw = 4'b0000; sample_en = 1'b1;
    repeat (3) @(negedge clock);
    check("t1_rst_out", int'(outv), 4'b1001);
    check("t1_rst_chg", int'(sensor_chg), 0);
    check("t1_rst_glitch", int'(glitch_cnt), 0);
    chk_on = 1'b1;
    reset = 1'b0; raw = 4'b1001;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      check("t1_out", int'(outv), 4'b1001);
      check("t1_chg", int'(sensor_chg), 0);
    end
    check("t1_glitch", int'(glitch_cnt), 0);

    // 2. barrier clear
    raw = 4'b1000;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      check("t2_barrier", int'(barrier), (k >= 6) ? 0 : 1);
      check("t2_chg", int'(sensor_chg), (k == 6) ? 1 : 0);
    end

    // 3. head glitch of 3 clocks
    raw = 4'b0000;
    repeat (3) @(negedge clock);
    raw = 4'b1000;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      check("t3_head", int'(head), 1);
      pulses += int'(sensor_chg);
    end
    check("t3_pulses", pulses, 0);
    check("t3_glitch", int'(glitch_cnt), (GL_EN != 0) ? 1 : 0);

    // 4. head and left change together
    raw = 4'b0100;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 5) check("t4_pre", int'(outv), 4'b1000);
      if (k == 6) check("t4_post", int'(outv), 4'b0100);
      pulses += int'(sensor_chg);
    end
    check("t4_pulses", pulses, 1);

    // 5. reset in the middle of an under count
    raw = 4'b0110;
    repeat (5) @(negedge clock);
    check("t5_pre", int'(outv), 4'b0100);
    reset = 1'b1;
    #1;
    check("t5_async_under", int'(under), 0);
    check("t5_async_out", int'(outv), 4'b1001);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      check("t5_out", int'(outv), (k == 6) ? 4'b0110 : 4'b1001);
    end
    check("t5_glitch", int'(glitch_cnt), 0);

    // 6. freeze for 5 edges during a barrier count
    raw = 4'b0111;
    repeat (4) @(negedge clock);
    sample_en = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge clock);
      pulses += int'(sensor_chg);
      check("t6_frozen", int'(barrier), 0);
    end
    sample_en = 1'b1;
    @(negedge clock);
    check("t6_e10", int'(barrier), 0);
    @(negedge clock);
    check("t6_e11", int'(barrier), 1);
    check("t6_e11_chg", int'(sensor_chg), 1);
    check("t6_pulses", pulses, 0);

    // 7. every channel toggling each cycle: output frozen, glitches saturate
    hold = outv;
    pulses = 0;
    for (int k = 0; k < 600; k++) begin
      raw = (k % 2 == 0) ? ~hold : hold;
      @(negedge clock);
      pulses += int'(sensor_chg);
    end
    raw = hold;
    repeat (3) @(negedge clock);
    check("t7_out", int'(outv), int'(hold));
    check("t7_pulses", pulses, 0);
    check("t7_glitch", int'(glitch_cnt), (GL_EN != 0) ? 255 : 0);

    // random phase: slow-ish channel changes, occasional freeze and reset
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) raw[i] = ~raw[i];
      end
      if (n % 500 < 250) begin
        if ($urandom_range(0, 1) == 0) raw = {raw[3:1], ~raw[0]};
      end
      sample_en = ($urandom_range(0, 9) != 0);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      @(negedge clock);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
